// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared types and constants for the iterative FP32 divider.
//   state_e      : controller states (IDLE, DIVIDE, NORM, DONE)
//   EXP_BIAS, EXP_W, FRAC_W, QUOT_BITS : FP32 field geometry
//   QNAN, POS_INF: canonical special results
//   FLAG_*       : bit positions inside the 4-bit flags vector
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } state_e;

  localparam int          EXP_BIAS  = 127;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned QUOT_BITS = 27;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int unsigned FLAG_INVALID   = 3;
  localparam int unsigned FLAG_DIV_ZERO  = 2;
  localparam int unsigned FLAG_OVERFLOW  = 1;
  localparam int unsigned FLAG_UNDERFLOW = 0;

endpackage

// File: rtl/fp_div_classify.sv
// fp_div_classify: combinational operand classification for fp_divider.
// Decides whether an a/b pair bypasses the datapath and, if so, what the
// result and flags are. Denormal operands (exp = 0) count as zero.
//   exp_a, exp_b : biased exponent fields of dividend / divisor
//   sign         : result sign (sa ^ sb)
//   special      : 1 when the special result overrides the datapath
//   spec_result  : overriding FP32 result
//   spec_flags   : overriding {invalid, div_by_zero, overflow, underflow}
module fp_div_classify
  import fp_div_pkg::*;
(
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             sign,
  output logic             special,
  output logic [31:0]      spec_result,
  output logic [3:0]       spec_flags
);

  logic a_zero;
  logic b_zero;
  logic a_infnan;
  logic b_infnan;

  always_comb begin
    a_zero   = (exp_a == '0);
    b_zero   = (exp_b == '0);
    a_infnan = (exp_a == '1);
    b_infnan = (exp_b == '1);

    special     = 1'b0;
    spec_result = '0;
    spec_flags  = '0;

    if (a_infnan || b_infnan || (a_zero && b_zero)) begin
      special                  = 1'b1;
      spec_result              = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (b_zero) begin
      special                   = 1'b1;
      spec_result               = POS_INF | {sign, 31'b0};
      spec_flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (a_zero) begin
      special     = 1'b1;
      spec_result = {sign, 31'b0};
    end
  end

endmodule

// File: rtl/fp_divider.sv
// fp_divider: iterative IEEE-754 single-precision divider, result = a / b.
// Restoring radix-2 division of the 24-bit significands, one quotient bit
// per clock, 27 quotient bits. out_valid rises 28 edges after acceptance.
// Denormal inputs are flushed to zero; no denormal outputs are produced.
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   a, b                 : dividend, divisor (FP32)
//   out_valid / out_ready: result handshake; result held until taken
//   result               : quotient (FP32)
//   flags                : {invalid, div_by_zero, overflow, underflow}
// Optional feature: define FP_DIV_RNE_EN for round-to-nearest-even;
// without it the quotient is truncated (round toward zero).
module fp_divider
  import fp_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [9:0]      exp_q, exp_d;
  logic [FRAC_W:0]        mb_q, mb_d;
  logic [FRAC_W+1:0]      rem_q, rem_d;
  logic [QUOT_BITS-1:0]   quot_q, quot_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   spec_q, spec_d;
  logic [31:0]            spec_res_q, spec_res_d;
  logic [3:0]             spec_flags_q, spec_flags_d;
  logic [31:0]            result_q, result_d;
  logic [3:0]             flags_q, flags_d;

  logic                   cls_special;
  logic [31:0]            cls_result;
  logic [3:0]             cls_flags;

  fp_div_classify u_classify (
    .exp_a       (a[30:23]),
    .exp_b       (b[30:23]),
    .sign        (a[31] ^ b[31]),
    .special     (cls_special),
    .spec_result (cls_result),
    .spec_flags  (cls_flags)
  );

  // One restoring step. R < 2*mb always holds, so R - mb fits and the
  // shifted remainder never loses a set bit.
  logic              rem_ge;
  logic [FRAC_W+1:0] rem_sub;

  always_comb begin
    rem_ge  = (rem_q >= {1'b0, mb_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  end

  // Normalisation, rounding and range check of the finished quotient.
  logic [FRAC_W-1:0] frac_t;
  logic [FRAC_W-1:0] frac_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_r;
  logic [31:0]       norm_result;
  logic [3:0]        norm_flags;
`ifdef FP_DIV_RNE_EN
  logic              guard;
  logic              sticky;
  logic              round_inc;
  logic [FRAC_W:0]   frac_inc;
`endif

  always_comb begin
    // a/b in (1/2, 2), so either q[26] or q[25] is the leading one.
    frac_t = quot_q[26] ? quot_q[25:3] : quot_q[24:2];
    exp_n  = quot_q[26] ? exp_q : (exp_q - 10'sd1);
`ifdef FP_DIV_RNE_EN
    guard     = quot_q[26] ? quot_q[2] : quot_q[1];
    sticky    = (quot_q[26] ? (|quot_q[1:0]) : quot_q[0]) | (|rem_q);
    round_inc = guard & (sticky | frac_t[0]);
    // Carry out of the fraction leaves frac = 0, i.e. mantissa 1.0.
    frac_inc  = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_inc};
    frac_r    = frac_inc[FRAC_W-1:0];
    exp_r     = exp_n + $signed({9'b0, frac_inc[FRAC_W]});
`else
    frac_r = frac_t;
    exp_r  = exp_n;
`endif
    norm_flags = '0;
    if (exp_r >= 10'sd255) begin
      norm_result               = POS_INF | {sign_q, 31'b0};
      norm_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      norm_result                = {sign_q, 31'b0};
      norm_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      norm_result = {sign_q, exp_r[7:0], frac_r};
    end
  end

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    exp_d        = exp_q;
    mb_d         = mb_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    cnt_d        = cnt_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    spec_flags_d = spec_flags_q;
    result_d     = result_q;
    flags_d      = flags_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d      = DIVIDE;
          sign_d       = a[31] ^ b[31];
          exp_d        = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                         + $signed(10'(EXP_BIAS));
          mb_d         = {1'b1, b[22:0]};
          rem_d        = {2'b01, a[22:0]};
          quot_d       = '0;
          cnt_d        = 5'(QUOT_BITS - 1);
          spec_d       = cls_special;
          spec_res_d   = cls_result;
          spec_flags_d = cls_flags;
        end
      end
      DIVIDE: begin
        // Bits arrive MSB first, so shifting them in lands the first one
        // at q[26] after 27 steps, same as writing q[cnt].
        quot_d = {quot_q[QUOT_BITS-2:0], rem_ge};
        rem_d  = rem_sub << 1;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == '0) begin
          state_d = NORM;
        end
      end
      NORM: begin
        result_d = spec_q ? spec_res_q : norm_result;
        flags_d  = spec_q ? spec_flags_q : norm_flags;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      mb_q         <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      cnt_q        <= '0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
      result_q     <= '0;
      flags_q      <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      exp_q        <= exp_d;
      mb_q         <= mb_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      cnt_q        <= cnt_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      spec_flags_q <= spec_flags_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: self-checking bench for fp_divider. Directed vectors,
// backpressure, reset abort and randomized operands compared against an
// exact-integer reference of FP32 division.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_cmp = 0;
  int n_err = 0;

  fp_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Exact reference: significand quotient from integer division with the
  // true remainder deciding round-to-nearest-even.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
    int ex, ey, e;
    logic s;
    longint unsigned mx, my, num, sig, rem;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    f  = 4'b0000;
    if (ex == 255 || ey == 255 || (ex == 0 && ey == 0)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (ey == 0) begin
      r = {s, 31'h7F800000}; f = 4'b0100;
    end else if (ex == 0) begin
      r = {s, 31'b0};
    end else begin
      mx = {40'b0, 1'b1, x[22:0]};
      my = {40'b0, 1'b1, y[22:0]};
      if (mx >= my) begin num = mx << 23; e = ex - ey + 127; end
      else          begin num = mx << 24; e = ex - ey + 126; end
      sig = num / my;
      rem = num % my;
`ifdef FP_DIV_RNE_EN
      if ((2 * rem > my) || ((2 * rem == my) && sig[0])) sig = sig + 1;
      if (sig == (64'd1 << 24)) begin sig = 64'd1 << 23; e = e + 1; end
`endif
      if (e >= 255) begin
        r = {s, 31'h7F800000}; f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'b0}; f = 4'b0001;
      end else begin
        r = {s, e[7:0], sig[22:0]};
      end
    end
  endfunction

  // Issues one operation; drains it if out_ready is high.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    check_eq("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = flags;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0)      e = 8'h00;
    else if (sel == 1) e = 8'hFF;
    else               e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  logic [31:0] r, er, held;
  logic [3:0]  f, ef;
  int          lat, seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_flags", {28'b0, flags}, 32'h0);

    run_op(32'h40C00000, 32'h40000000, r, f, lat);
    check_eq("six_div_two", r, 32'h40400000);
    check_eq("six_div_two_flags", {28'b0, f}, 32'h0);
    check_eq("six_div_two_latency", lat, 28);
    check_eq("in_ready_after_xfer", {31'b0, in_ready}, 32'd1);

    run_op(32'h3F800000, 32'h40400000, r, f, lat);
`ifdef FP_DIV_RNE_EN
    check_eq("one_third", r, 32'h3EAAAAAB);
`else
    check_eq("one_third", r, 32'h3EAAAAAA);
`endif
    check_eq("one_third_flags", {28'b0, f}, 32'h0);

    run_op(32'hBF800000, 32'h00000000, r, f, lat);
    check_eq("div_by_zero", r, 32'hFF800000);
    check_eq("div_by_zero_flags", {28'b0, f}, 32'h4);
    check_eq("special_latency", lat, 28);

    run_op(32'h00000000, 32'h00000000, r, f, lat);
    check_eq("zero_div_zero", r, 32'h7FC00000);
    check_eq("zero_div_zero_flags", {28'b0, f}, 32'h8);

    run_op(32'h7F000000, 32'h3E800000, r, f, lat);
    check_eq("overflow", r, 32'h7F800000);
    check_eq("overflow_flags", {28'b0, f}, 32'h2);

    run_op(32'h00800000, 32'h40000000, r, f, lat);
    check_eq("underflow", r, 32'h00000000);
    check_eq("underflow_flags", {28'b0, f}, 32'h1);

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    run_op(32'h41200000, 32'h40A00000, held, f, lat);
    check_eq("bp_result", held, 32'h40000000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("bp_result_stable", result, held);
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_valid", {31'b0, out_valid}, 32'd0);
    check_eq("bp_release_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bp_not_captured", {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Reset during iteration 10 aborts the operation.
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("abort_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("abort_no_valid", seen, 0);
    run_op(32'h40C00000, 32'h40000000, r, f, lat);
    check_eq("after_abort", r, 32'h40400000);
    check_eq("after_abort_flags", {28'b0, f}, 32'h0);

    // Randomized operands against the reference.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = rand_fp();
      rb = rand_fp();
      ref_div(ra, rb, er, ef);
      run_op(ra, rb, r, f, lat);
      check_eq("rand_result", r, er);
      check_eq("rand_flags", {28'b0, f}, {28'b0, ef});
      check_eq("rand_latency", lat, 28);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
